// File: rtl/f2f_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f2f_pkg
// Description : Shared constants and types for the float-to-fixed pipeline:
//               IEEE-754 single field widths, operand classes, flag indices.
// Revision    : 1.0 - initial release
// ============================================================================
package f2f_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;

    // Bit positions inside the 3-bit flags word {nan, ovf, inexact}
    localparam int FLAG_NAN     = 2;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_INEXACT = 0;

    // Signed shift-amount width; covers exp-150+fixpointpos for fixpointpos < 256
    localparam int SH_W = 10;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        SUBNORM = 3'd1,
        NORMAL  = 3'd2,
        INF     = 3'd3,
        NAN     = 3'd4
    } f2f_class_e;

endpackage
`default_nettype wire

// File: rtl/f2f_shift.sv
`default_nettype none
// ============================================================================
// Module      : f2f_shift
// Description : Combinational barrel shifter. Shifts the 24-bit significand
//               left or right by a signed amount, returning the integer
//               magnitude (top bit = "exceeds FIX_W bits"), guard and sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module f2f_shift
    import f2f_pkg::*;
#(
    parameter int FIX_W = 32
) (
    input  logic [MANT_W:0]   mant_i,
    input  logic [SH_W-1:0]   shamt_i,
    output logic [FIX_W:0]    mag_o,
    output logic              guard_o,
    output logic              sticky_o
);

    // Integer field wide enough for any left shift below FIX_W; fraction field
    // keeps every bit of a right shift up to MANT_W+2 positions.
    localparam int c_INT_W  = FIX_W + MANT_W + 1;
    localparam int c_FRAC_W = MANT_W + 3;
    localparam int c_TOT_W  = c_INT_W + c_FRAC_W;

    logic [c_TOT_W-1:0] w_base;
    logic [c_TOT_W-1:0] w_x;
    logic [SH_W-1:0]    w_rsh;

    // Place the significand at the binary point, shift, then split into fields
    always_comb begin
        w_base   = c_TOT_W'(mant_i) << c_FRAC_W;
        w_rsh    = -shamt_i;
        w_x      = '0;
        mag_o    = '0;
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        if (!shamt_i[SH_W-1]) begin
            if (shamt_i >= SH_W'(FIX_W)) begin
                // Leading one lands at or above bit FIX_W: certainly too big
                mag_o[FIX_W] = 1'b1;
            end else begin
                w_x      = w_base << shamt_i;
                mag_o    = {|w_x[c_TOT_W-1:c_FRAC_W+FIX_W], w_x[c_FRAC_W+FIX_W-1:c_FRAC_W]};
                guard_o  = w_x[c_FRAC_W-1];
                sticky_o = |w_x[c_FRAC_W-2:0];
            end
        end else begin
            if (w_rsh > SH_W'(c_FRAC_W - 1)) begin
                // Whole significand lies below the guard position
                sticky_o = 1'b1;
            end else begin
                w_x      = w_base >> w_rsh;
                mag_o    = {|w_x[c_TOT_W-1:c_FRAC_W+FIX_W], w_x[c_FRAC_W+FIX_W-1:c_FRAC_W]};
                guard_o  = w_x[c_FRAC_W-1];
                sticky_o = |w_x[c_FRAC_W-2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/float_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : float_to_fixed_pipe
// Description : 3-stage IEEE-754 single to signed fixed-point converter with
//               valid/ready flow control. S1 unpack/classify, S2 shift,
//               S3 round/negate/saturate. Counts saturated beats.
//               Macro F2F_ROUND_NEAREST_EN: round to nearest-even instead of
//               truncating toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_fixed_pipe
    import f2f_pkg::*;
#(
    parameter int FIX_W = 32,
    parameter int POS_W = $clog2(FIX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      float,
    input  logic [POS_W-1:0] fixpointpos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FIX_W-1:0] result,
    output logic [2:0]       flags,
    output logic [15:0]      sat_count
);

    localparam logic [FIX_W-1:0] c_FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] c_FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};

    // Whole pipeline moves as one; a held output stalls every stage
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack / classify ----------------
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_man;
    f2f_class_e        w_cls;
    logic [SH_W-1:0]   w_sh;

    assign w_exp = float[30:23];
    assign w_man = float[22:0];
    assign w_sh  = SH_W'(w_exp) - SH_W'(EXP_BIAS + MANT_W) + SH_W'(fixpointpos);

    // Classify the operand from its exponent and mantissa fields
    always_comb begin
        w_cls = NORMAL;
        if (w_exp == '0)
            w_cls = (w_man == '0) ? ZERO : SUBNORM;
        else if (w_exp == '1)
            w_cls = (w_man == '0) ? INF : NAN;
    end

    logic             s1_valid_q;
    logic             s1_sign_q;
    f2f_class_e       s1_cls_q;
    logic [MANT_W:0]  s1_mant_q;
    logic [SH_W-1:0]  s1_sh_q;

    // S1 register: capture the accepted beat with its own shift amount
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_cls_q   <= ZERO;
            s1_mant_q  <= '0;
            s1_sh_q    <= '0;
        end else if (w_adv) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= float[31];
            s1_cls_q   <= w_cls;
            s1_mant_q  <= {1'b1, w_man};
            s1_sh_q    <= w_sh;
        end
    end

    // ---------------- S2: barrel shift ----------------
    logic [FIX_W:0] w_mag;
    logic           w_guard;
    logic           w_sticky;

    f2f_shift #(.FIX_W(FIX_W)) u_shift (
        .mant_i   (s1_mant_q),
        .shamt_i  (s1_sh_q),
        .mag_o    (w_mag),
        .guard_o  (w_guard),
        .sticky_o (w_sticky)
    );

    logic           s2_valid_q;
    logic           s2_sign_q;
    f2f_class_e     s2_cls_q;
    logic [FIX_W:0] s2_mag_q;
    logic           s2_guard_q;
    logic           s2_sticky_q;

    // S2 register: shifted magnitude plus the bits it discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= ZERO;
            s2_mag_q    <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else if (w_adv) begin
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_cls_q    <= s1_cls_q;
            s2_mag_q    <= w_mag;
            s2_guard_q  <= w_guard;
            s2_sticky_q <= w_sticky;
        end
    end

    // ---------------- S3: round / negate / saturate ----------------
    logic             w_inc;
    logic [FIX_W:0]   w_sum;
    logic             w_big;
    logic [FIX_W-1:0] w_rmag;
    logic [FIX_W-1:0] w_res;
    logic [2:0]       w_flg;

    // Round the magnitude, apply sign and clamp to the signed range
    always_comb begin
        w_inc = 1'b0;
`ifdef F2F_ROUND_NEAREST_EN
        w_inc = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
`endif
        w_sum  = {1'b0, s2_mag_q[FIX_W-1:0]} + {{FIX_W{1'b0}}, w_inc};
        w_big  = s2_mag_q[FIX_W] | w_sum[FIX_W];
        w_rmag = w_sum[FIX_W-1:0];
        w_res  = '0;
        w_flg  = '0;
        case (s2_cls_q)
            NAN: begin
                w_flg[FLAG_NAN] = 1'b1;
            end
            INF: begin
                w_res           = s2_sign_q ? c_FIX_MIN : c_FIX_MAX;
                w_flg[FLAG_OVF] = 1'b1;
            end
            SUBNORM: begin
                w_flg[FLAG_INEXACT] = 1'b1;
            end
            NORMAL: begin
                w_flg[FLAG_INEXACT] = s2_guard_q | s2_sticky_q;
                if (!s2_sign_q) begin
                    if (w_big || w_rmag[FIX_W-1]) begin
                        w_res           = c_FIX_MAX;
                        w_flg[FLAG_OVF] = 1'b1;
                    end else begin
                        w_res = w_rmag;
                    end
                end else begin
                    // Magnitude 2^(FIX_W-1) exactly is the legal minimum
                    if (w_big || (w_rmag[FIX_W-1] && |w_rmag[FIX_W-2:0])) begin
                        w_res           = c_FIX_MIN;
                        w_flg[FLAG_OVF] = 1'b1;
                    end else begin
                        w_res = -w_rmag;
                    end
                end
            end
            default: ;
        endcase
    end

    logic             s3_valid_q;
    logic [FIX_W-1:0] result_q;
    logic [2:0]       flags_q;
    logic [15:0]      sat_q;

    // Output register: holds steady while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else if (w_adv) begin
            s3_valid_q <= s2_valid_q;
            result_q   <= w_res;
            flags_q    <= w_flg;
        end
    end

    // Count delivered overflow beats, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            sat_q <= '0;
        else if (s3_valid_q && out_ready && flags_q[FLAG_OVF] && (sat_q != 16'hFFFF))
            sat_q <= sat_q + 16'd1;
    end

    assign out_valid = s3_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign sat_count = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_float_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_to_fixed_pipe
// Description : Self-checking bench for float_to_fixed_pipe (FIX_W=32) with a
//               scoreboard queue of expected beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_fixed_pipe;

    localparam int FIX_W = 32;
    localparam int POS_W = $clog2(FIX_W);

`ifdef F2F_ROUND_NEAREST_EN
    localparam logic [FIX_W-1:0] R_2P5  = 32'd2;
    localparam logic [FIX_W-1:0] R_0P75 = 32'd1;
`else
    localparam logic [FIX_W-1:0] R_2P5  = 32'd2;
    localparam logic [FIX_W-1:0] R_0P75 = 32'd0;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [31:0]      flt       = '0;
    logic [POS_W-1:0] fpos      = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [FIX_W-1:0] result;
    logic [2:0]       flags;
    logic [15:0]      sat_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [FIX_W-1:0] res;
        logic [2:0]       flg;
        string            tag;
        int               stamp;
        bit               chk_lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    float_to_fixed_pipe #(.FIX_W(FIX_W), .POS_W(POS_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .float       (flt),
        .fixpointpos (fpos),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every delivered beat is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk({mon_e.tag, "_result"}, 64'(result), 64'(mon_e.res));
                chk({mon_e.tag, "_flags"}, 64'(flags), 64'(mon_e.flg));
                if (mon_e.chk_lat)
                    chk({mon_e.tag, "_latency"}, 64'(cyc - mon_e.stamp), 64'd3);
            end
        end
    end

    // Offer one beat and wait (bounded) until it is accepted
    task automatic send(input logic [31:0] f, input int pos, input logic [FIX_W-1:0] r,
                        input logic [2:0] fl, input string tag, input bit lat);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        flt      = f;
        fpos     = POS_W'(pos);
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        if (in_ready) begin
            e.res     = r;
            e.flg     = fl;
            e.tag     = tag;
            e.stamp   = cyc;
            e.chk_lat = lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drained"}, 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // 1.5 at Q16 with latency check
        send(32'h3FC00000, 16, 32'h00018000, 3'b000, "p1_5", 1'b1);
        idle();
        drain("p1_5");

        // Back-to-back: -2.25 Q8, then 1e10 saturating
        send(32'hC0100000, 8, 32'hFFFFFDC0, 3'b000, "m2_25", 1'b0);
        send(32'h501502F9, 0, 32'h7FFFFFFF, 3'b010, "big1e10", 1'b0);
        idle();
        drain("big1e10");
        chk("sat_count_1", 64'(sat_count), 64'd1);

        send(32'hFF800000, 0, 32'h80000000, 3'b010, "ninf", 1'b0);
        idle();
        drain("ninf");
        chk("sat_count_2", 64'(sat_count), 64'd2);

        // Special values, rounding and range boundaries, streamed
        send(32'h7FC00000, 0, 32'h00000000, 3'b100, "nan", 1'b0);
        send(32'h80000000, 0, 32'h00000000, 3'b000, "mzero", 1'b0);
        send(32'h40200000, 0, R_2P5, 3'b001, "p2_5", 1'b0);
        send(32'h3F400000, 0, R_0P75, 3'b001, "p0_75", 1'b0);
        send(32'h00000001, 0, 32'h00000000, 3'b001, "subnorm", 1'b0);
        send(32'h2EDBE6FF, 0, 32'h00000000, 3'b001, "tiny", 1'b0);
        send(32'hCF000000, 0, 32'h80000000, 3'b000, "exact_min", 1'b0);
        send(32'h7F800000, 0, 32'h7FFFFFFF, 3'b010, "pinf", 1'b0);
        send(32'h4F000000, 0, 32'h7FFFFFFF, 3'b010, "p2pow31", 1'b0);
        idle();
        drain("mixed");
        chk("sat_count_4", 64'(sat_count), 64'd4);

        // Backpressure: fill the pipe with out_ready low, fixpointpos varies
        out_ready = 1'b0;
        send(32'h3F800000, 0, 32'd1, 3'b000, "bp1", 1'b0);
        send(32'h40000000, 1, 32'd4, 3'b000, "bp2", 1'b0);
        send(32'h40400000, 2, 32'd12, 3'b000, "bp3", 1'b0);
        idle();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_result", 64'(result), 64'd1);
            chk("bp_hold_flags", 64'(flags), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h40800000, 3, 32'd32, 3'b000, "bp4", 1'b0);
        send(32'h40A00000, 4, 32'd80, 3'b000, "bp5", 1'b0);
        send(32'h40C00000, 5, 32'd192, 3'b000, "bp6", 1'b0);
        idle();
        drain("bp");

        // Reset with a beat in flight and a simultaneous accept
        in_valid = 1'b1;
        flt      = 32'h3F800000;
        fpos     = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("flush_sat_count", 64'(sat_count), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("flush_no_output", 64'(out_valid), 64'd0);
        end
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_to_fixed_pipe.md
FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

Interface
REQ-001 The module SHALL have parameter FIX_W, default 32, meaning the signed output width; legal range 8..64.
REQ-002 The module SHALL have parameter POS_W, default $clog2(FIX_W), meaning the width of the fixpointpos input.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The module SHALL have port in_valid, input, 1: an input beat is offered.
REQ-006 The module SHALL have port in_ready, output, 1: a beat is accepted when in_valid && in_ready.
REQ-007 The module SHALL have port float, input, 32: an IEEE-754 single-precision operand.
REQ-008 The module SHALL have port fixpointpos, input, POS_W: the number of fractional bits of the result, sampled with the beat.
REQ-009 The module SHALL have port out_valid, output, 1: the result beat is valid.
REQ-010 The module SHALL have port out_ready, input, 1: the downstream accepts the beat.
REQ-011 The module SHALL have port result, output, FIX_W: the two's-complement fixed-point value.
REQ-012 The module SHALL have port flags, output, 3: {nan, ovf, inexact} for the beat on result.
REQ-013 The module SHALL have port sat_count, output, 16: the saturating count of delivered beats with ovf=1.

Function
REQ-014 The datapath SHALL be a 3-stage pipeline: S1 unpack/classify, S2 barrel shift, S3 round/negate/saturate; latency 3 cycles from accept to out_valid when no stall occurs.
REQ-015 The pipeline SHALL advance when (!out_valid || out_ready); in_ready SHALL equal this advance term, and the pipeline SHALL sustain one beat per cycle.
REQ-016 While stalled, result, flags and out_valid SHALL hold stable, and no beat SHALL be dropped or duplicated.
REQ-017 fixpointpos SHALL travel with its beat; changing it between beats SHALL NOT affect beats already in flight.
REQ-018 Magnitude SHALL be computed as {1,mantissa} shifted by (exp-127-23+fixpointpos), left or right; bits shifted out on the right SHALL form the guard/sticky bits.
REQ-019 A negative value SHALL be returned as the two's complement of the rounded magnitude.
REQ-020 Any nonzero discarded bits SHALL set inexact.
REQ-021 If the signed value exceeds [-2^(FIX_W-1), 2^(FIX_W-1)-1], including after the rounding increment, result SHALL saturate to that bound with ovf=1; an exact -2^(FIX_W-1) SHALL NOT set ovf.
REQ-022 NaN SHALL give result 0 with nan=1; +Inf and -Inf SHALL give the max and min bound respectively with ovf=1.
REQ-023 +0, -0 and subnormals SHALL give result 0; a subnormal SHALL set inexact=1.
REQ-024 sat_count SHALL increment on each out_valid && out_ready beat with ovf=1 and SHALL stick at 0xFFFF.

Reset
REQ-025 On rst, all valid bits SHALL clear, and result, flags and sat_count SHALL be 0.
REQ-026 in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-027 Beats in flight during rst SHALL be discarded, and rst SHALL win over a simultaneous accept.

Configuration
REQ-028 With macro F2F_ROUND_NEAREST_EN defined, S3 SHALL round magnitude to nearest, ties to even; without it, S3 SHALL truncate the magnitude (round toward zero).

Structure
REQ-029 A shared package f2f_pkg SHALL hold the float field constants (EXP_BIAS=127, MANT_W=23, EXP_W=8), the class enum {ZERO, SUBNORM, NORMAL, INF, NAN}, and the flag bit indices.
REQ-030 The S2 shifter SHALL be a sub-module f2f_shift (parameter FIX_W) returning {shifted magnitude, guard, sticky}.

Verification
REQ-031 The bench SHALL check: 0x3FC00000 (1.5), fixpointpos=16, FIX_W=32 -> result 0x00018000 exactly 3 cycles after accept, flags=000.
REQ-032 The bench SHALL check: 0xC0100000 (-2.25), fixpointpos=8 -> result 0xFFFFFDC0, flags=000.
REQ-033 The bench SHALL check: 0x501502F9 (1e10), fixpointpos=0 -> result 0x7FFFFFFF, ovf=1, sat_count=1; then 0xFF800000 (-Inf) -> result 0x80000000, sat_count=2.
REQ-034 The bench SHALL check: 0x7FC00000 (NaN) -> result 0, nan=1; and 0x80000000 (-0) -> result 0, flags=000.
REQ-035 The bench SHALL check: 0x40200000 (2.5), fixpointpos=0 -> result 2 with the macro and 2 without it; 0x3F400000 (0.75) -> 1 with the macro and 0 without it; inexact=1 in all four cases.
REQ-036 The bench SHALL check backpressure: stream 6 beats with out_ready=0 for 5 cycles -> in_ready=0 once 3 beats are held, result stable, then all 6 results delivered in order with none lost.
